lock_error_monitor: RTL and testbench
=====================================

# lock_error_monitor

Streaming error-metric stage that sits directly downstream of the key-locked 32-bit lower-part-OR ripple-carry adder. Each cycle it takes the locked adder's 33-bit result and the golden result from an unlocked reference instance, then accumulates three metrics over a fixed window of vectors: mismatching-vector count, total output Hamming distance, and maximum per-vector Hamming distance. At each window boundary it emits one report over a valid/ready handshake, so key sweeps (correct key, HD1…HD6 key corruptions) can be scored in hardware rather than by post-processing monitor dumps.

## Interface
Parameters:
- `WIDTH`, 33, result width (adder width + carry-out).
- `WIN_LEN`, 10000, vectors per report window. Must be ≥ 4.
- `ACC_W`, 32, width of the count and sum accumulators.
- `HD_W`, `$clog2(WIDTH+1)`, per-vector Hamming-distance width (6 for 33).

Ports:
- `clk_i`  in  1  clock; all logic rising-edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `in_valid_i`  in  1  vector present.
- `in_ready_o`  out  1  vector accepted when `in_valid_i && in_ready_o`.
- `locked_i`  in  WIDTH  result from the locked adder.
- `golden_i`  in  WIDTH  result from the unlocked adder.
- `clear_i`  in  1  synchronous restart of the current window.
- `rpt_valid_o`  out  1  report available.
- `rpt_ready_i`  in  1  report consumed when `rpt_valid_o && rpt_ready_i`.
- `rpt_err_cnt_o`  out  ACC_W  vectors with `locked_i != golden_i`.
- `rpt_hd_sum_o`  out  ACC_W  sum of popcount(`locked_i ^ golden_i`).
- `rpt_hd_max_o`  out  HD_W  maximum per-vector popcount.
- `rpt_abs_max_o`  out  WIDTH  maximum |locked − golden|. Present only with `LOCK_MON_ABS_ERR_EN`.

## Operation
- Pipeline:
  - S1 registers `x = locked ^ golden`, the 1-bit mismatch flag and the valid bit.
  - S2 computes popcount(x) and updates the accumulators and window counter `win_cnt`.
- Accumulators saturate at all-ones and never wrap. Err count and HD sum are unsigned. HD max is compared as unsigned.
- FSM has two states, ACCUM and REPORT.
  - ACCUM → REPORT when S2 updates with `win_cnt == WIN_LEN-1`. On that cycle:
    - The accumulators' final values, including the current vector, are copied into the report registers.
    - The accumulators and `win_cnt` are zeroed.
    - `rpt_valid_o` is set.
  - REPORT → ACCUM on report handshake. `rpt_valid_o` clears on the next edge.
- `in_ready_o = (state == ACCUM)`.
  - Up to 2 vectors may still be in S1/S2 when REPORT is entered. They accumulate into the next window.
  - `WIN_LEN ≥ 4` guarantees a second window cannot complete while a report is pending.
- Report outputs are stable while `rpt_valid_o` is high and the report has not been consumed.
- `clear_i` high:
  - Flushes the S1/S2 valid bits and zeros the accumulators and `win_cnt` on the next edge.
  - Does not affect a pending report or the FSM state.
  - If clear coincides with the final-vector update, clear wins: no report is generated.
- Simultaneous report handshake and accepted input vector: both take effect.

## Timing
- Reset values:
  - `rpt_valid_o` = 0.
  - All `rpt_*` data outputs = 0.
  - Accumulators and `win_cnt` = 0.
  - FSM = ACCUM, so `in_ready_o` = 1.
  - Pipeline valid bits = 0.
- Latency: `rpt_valid_o` rises 2 cycles after the edge that accepts the WIN_LEN-th vector of a window.
- Throughput: 1 vector per cycle in ACCUM. Report backpressure only stalls input while the FSM is in REPORT.
- Reset assertion mid-window or mid-report discards all state immediately, asynchronously. After release the block starts a fresh window.

## Configuration
- `LOCK_MON_ABS_ERR_EN` defined:
  - S1 also registers the WIDTH-bit `|locked_i − golden_i|`, computed by unsigned subtraction with swap.
  - S2 tracks its maximum.
  - The value is snapshotted into `rpt_abs_max_o` on the same rules as the other metrics.
- Undefined: the port, the subtractor and its registers are absent. All other behaviour is identical.

## Test plan
All scenarios use `WIN_LEN=8`.
- **Identity:** 8 vectors with `locked_i == golden_i`, `rpt_ready_i=1` → one report with err_cnt=0, hd_sum=0, hd_max=0; `rpt_valid_o` high for exactly 1 cycle.
- **Single-bit corruption:** 8 vectors with `locked_i = golden_i ^ 33'h1`, plus one vector `locked_i = golden_i ^ 33'h1_FFFF_FFFF` in a second window → window 1 report: err_cnt=8, hd_sum=8, hd_max=1; window 2 report shows hd_max=33.
- **Backpressure:** `rpt_ready_i=0` for 20 cycles after a window completes, with `in_valid_i` held high → `in_ready_o` low throughout; report values stable; after the handshake the next window reports exactly 8 vectors, including the ≤2 in-flight vectors.
- **Clear:** `clear_i` pulsed after 5 mismatching vectors, then 8 matching vectors → a single report with err_cnt=0; `clear_i` on the final-vector update cycle → no report.
- **Reset mid-window:** `rst_ni` low for 1 cycle after 6 vectors → all outputs at reset values; the next report counts only vectors accepted after release.
- **Absolute error (macro on):** golden=100, locked=37, then golden=5, locked=300 → `rpt_abs_max_o` = 295.

Source files
------------

// File: rtl/lock_error_monitor.sv
// lock_error_monitor: scores a key-locked adder against its unlocked twin.
// Per vector: x = locked ^ golden (S1), popcount(x) (S2), then the window
// accumulators (error count, Hamming sum, Hamming max) update. Every WIN_LEN
// counted vectors the totals are snapshotted into a report held on a
// valid/ready handshake; input is stalled only while a report is pending.
// Optional feature macro: LOCK_MON_ABS_ERR_EN adds max |locked - golden|.
module lock_error_monitor #(
  parameter int WIDTH   = 33,
  parameter int WIN_LEN = 10000,
  parameter int ACC_W   = 32,
  parameter int HD_W    = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] locked_i,
  input  logic [WIDTH-1:0] golden_i,
  input  logic             clear_i,
  output logic             rpt_valid_o,
  input  logic             rpt_ready_i,
  output logic [ACC_W-1:0] rpt_err_cnt_o,
  output logic [ACC_W-1:0] rpt_hd_sum_o,
  output logic [HD_W-1:0]  rpt_hd_max_o
`ifdef LOCK_MON_ABS_ERR_EN
  ,
  output logic [WIDTH-1:0] rpt_abs_max_o
`endif
);

  localparam int CNT_W = $clog2(WIN_LEN);

  typedef enum logic [0:0] {
    ACCUM  = 1'b0,
    REPORT = 1'b1
  } state_t;

  function automatic logic [HD_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [HD_W-1:0] c;
    c = {HD_W{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      c = c + HD_W'(v[i]);
    end
    return c;
  endfunction

  // Unsigned add that sticks at all-ones instead of wrapping.
  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                input logic [ACC_W-1:0] b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[ACC_W]) begin
      return {ACC_W{1'b1}};
    end else begin
      return s[ACC_W-1:0];
    end
  endfunction

  state_t             state, state_nxt;
  logic               accept;
  logic               s1_valid, s1_mis;
  logic [WIDTH-1:0]   s1_x;
  logic               s2_valid, s2_mis;
  logic [HD_W-1:0]    s2_hd;
  logic [ACC_W-1:0]   err_acc, sum_acc, err_nxt, sum_nxt;
  logic [HD_W-1:0]    max_acc, max_nxt;
  logic [CNT_W-1:0]   win_cnt;
  logic               last_update;
  logic [ACC_W-1:0]   rpt_err, rpt_sum;
  logic [HD_W-1:0]    rpt_max;

  assign accept      = in_valid_i && in_ready_o;
  assign in_ready_o  = (state == ACCUM);
  assign rpt_valid_o = (state == REPORT);
  // Clear beats the window boundary: a cleared final update never reports.
  assign last_update = s2_valid && (win_cnt == CNT_W'(WIN_LEN - 1)) && !clear_i;

  assign rpt_err_cnt_o = rpt_err;
  assign rpt_hd_sum_o  = rpt_sum;
  assign rpt_hd_max_o  = rpt_max;

  // S1: capture the difference pattern and mismatch flag of an accepted vector.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_mis   <= 1'b0;
      s1_x     <= {WIDTH{1'b0}};
    end else if (clear_i) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_x   <= locked_i ^ golden_i;
        s1_mis <= (locked_i != golden_i);
      end
    end
  end

  // S2: per-vector Hamming distance, ready for the accumulators.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_valid <= 1'b0;
      s2_mis   <= 1'b0;
      s2_hd    <= {HD_W{1'b0}};
    end else if (clear_i) begin
      s2_valid <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_hd  <= popcount(s1_x);
        s2_mis <= s1_mis;
      end
    end
  end

  // Metric values including the vector currently in S2.
  always_comb begin
    err_nxt = sat_add(err_acc, ACC_W'(s2_mis));
    sum_nxt = sat_add(sum_acc, ACC_W'(s2_hd));
    max_nxt = max_acc;
    if (s2_hd > max_acc) begin
      max_nxt = s2_hd;
    end else begin
      max_nxt = max_acc;
    end
  end

  // Window accumulators: restart on clear or at the window boundary.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_acc <= {ACC_W{1'b0}};
      sum_acc <= {ACC_W{1'b0}};
      max_acc <= {HD_W{1'b0}};
      win_cnt <= {CNT_W{1'b0}};
    end else if (clear_i || last_update) begin
      err_acc <= {ACC_W{1'b0}};
      sum_acc <= {ACC_W{1'b0}};
      max_acc <= {HD_W{1'b0}};
      win_cnt <= {CNT_W{1'b0}};
    end else if (s2_valid) begin
      err_acc <= err_nxt;
      sum_acc <= sum_nxt;
      max_acc <= max_nxt;
      win_cnt <= win_cnt + CNT_W'(1);
    end
  end

  // Report snapshot: written only at a window boundary, held otherwise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rpt_err <= {ACC_W{1'b0}};
      rpt_sum <= {ACC_W{1'b0}};
      rpt_max <= {HD_W{1'b0}};
    end else if (last_update) begin
      rpt_err <= err_nxt;
      rpt_sum <= sum_nxt;
      rpt_max <= max_nxt;
    end
  end

`ifdef LOCK_MON_ABS_ERR_EN
  logic [WIDTH-1:0] s1_abs, s2_abs, abs_acc, abs_nxt, rpt_abs;

  assign rpt_abs_max_o = rpt_abs;

  // Absolute-error path: S1 magnitude, S2 delay, then window maximum.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_abs <= {WIDTH{1'b0}};
      s2_abs <= {WIDTH{1'b0}};
    end else begin
      if (accept) begin
        s1_abs <= (locked_i >= golden_i) ? (locked_i - golden_i) : (golden_i - locked_i);
      end
      if (s1_valid) begin
        s2_abs <= s1_abs;
      end
    end
  end

  // Running absolute-error maximum including the S2 vector.
  always_comb begin
    abs_nxt = abs_acc;
    if (s2_abs > abs_acc) begin
      abs_nxt = s2_abs;
    end else begin
      abs_nxt = abs_acc;
    end
  end

  // Absolute-error accumulator and its report snapshot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      abs_acc <= {WIDTH{1'b0}};
      rpt_abs <= {WIDTH{1'b0}};
    end else begin
      if (last_update) begin
        rpt_abs <= abs_nxt;
      end
      if (clear_i || last_update) begin
        abs_acc <= {WIDTH{1'b0}};
      end else if (s2_valid) begin
        abs_acc <= abs_nxt;
      end
    end
  end
`endif

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: enter REPORT at a window boundary, leave on handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM: begin
        if (last_update) begin
          state_nxt = REPORT;
        end else begin
          state_nxt = ACCUM;
        end
      end
      REPORT: begin
        if (rpt_ready_i) begin
          state_nxt = ACCUM;
        end else begin
          state_nxt = REPORT;
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

endmodule

// File: tb/tb_lock_error_monitor.sv
// Self-checking bench for lock_error_monitor with WIN_LEN = 8.
// The reference model keeps the accepted vectors of the open window in queues,
// counts them two edges after acceptance and, when eight have been counted,
// computes the metrics with $countones / plain arithmetic.
module tb_lock_error_monitor;

  localparam int WIDTH = 33;
  localparam int WIN   = 8;
  localparam int ACC_W = 32;
  localparam int HD_W  = 6;

  logic             clk = 1'b0;
  logic             rst_ni;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] locked;
  logic [WIDTH-1:0] golden;
  logic             clear;
  logic             rpt_valid;
  logic             rpt_ready;
  logic [ACC_W-1:0] rpt_err;
  logic [ACC_W-1:0] rpt_sum;
  logic [HD_W-1:0]  rpt_max;
`ifdef LOCK_MON_ABS_ERR_EN
  logic [WIDTH-1:0] rpt_abs;
`endif

  always #5 clk = ~clk;

  lock_error_monitor #(.WIDTH(WIDTH), .WIN_LEN(WIN), .ACC_W(ACC_W), .HD_W(HD_W)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .locked_i      (locked),
    .golden_i      (golden),
    .clear_i       (clear),
    .rpt_valid_o   (rpt_valid),
    .rpt_ready_i   (rpt_ready),
    .rpt_err_cnt_o (rpt_err),
    .rpt_hd_sum_o  (rpt_sum),
    .rpt_hd_max_o  (rpt_max)
`ifdef LOCK_MON_ABS_ERR_EN
    ,
    .rpt_abs_max_o (rpt_abs)
`endif
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  logic [WIDTH-1:0] win_lk[$];
  logic [WIDTH-1:0] win_gd[$];
  logic             a_v, b_v;
  logic [WIDTH-1:0] a_l, a_g, b_l, b_g;
  logic             m_pending;
  logic [ACC_W-1:0] m_err, m_sum;
  logic [HD_W-1:0]  m_max;
  logic [WIDTH-1:0] m_abs;

  task automatic model_reset();
    win_lk.delete();
    win_gd.delete();
    a_v = 1'b0; b_v = 1'b0;
    a_l = '0; a_g = '0; b_l = '0; b_g = '0;
    m_pending = 1'b0;
    m_err = '0; m_sum = '0; m_max = '0; m_abs = '0;
  endtask

  task automatic model_report();
    int e, s, mx;
    logic [WIDTH-1:0] d, ab, amax;
    e = 0; s = 0; mx = 0; amax = '0;
    foreach (win_lk[i]) begin
      d = win_lk[i] ^ win_gd[i];
      if (d != '0) e++;
      s += $countones(d);
      if ($countones(d) > mx) mx = $countones(d);
      ab = (win_lk[i] > win_gd[i]) ? win_lk[i] - win_gd[i] : win_gd[i] - win_lk[i];
      if (ab > amax) amax = ab;
    end
    m_err = ACC_W'(e);
    m_sum = ACC_W'(s);
    m_max = HD_W'(mx);
    m_abs = amax;
    m_pending = 1'b1;
    win_lk.delete();
    win_gd.delete();
  endtask

  // One rising edge of the model, using the inputs currently driven.
  task automatic model_edge();
    logic acc_now, hs;
    acc_now = in_valid && !m_pending;
    hs      = m_pending && rpt_ready;
    if (hs) m_pending = 1'b0;
    if (clear) begin
      a_v = 1'b0; b_v = 1'b0;
      win_lk.delete();
      win_gd.delete();
    end else begin
      if (b_v) begin
        win_lk.push_back(b_l);
        win_gd.push_back(b_g);
        if (win_lk.size() == WIN) model_report();
      end
      b_v = a_v; b_l = a_l; b_g = a_g;
      a_v = acc_now; a_l = locked; a_g = golden;
    end
  endtask

  // Drive one cycle of inputs, advance DUT and model, settle before sampling.
  task automatic cyc(input logic v, input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] g,
                     input logic c, input logic r);
    in_valid = v; locked = l; golden = g; clear = c; rpt_ready = r;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [WIDTH-1:0] rnd_word();
    return {1'($urandom_range(1, 0)), 32'($urandom)};
  endfunction

  function automatic logic [WIDTH-1:0] rnd_mask();
    logic [WIDTH-1:0] m;
    m = rnd_word() & rnd_word() & rnd_word();
    if ($urandom_range(3, 0) == 0) m = '0;
    return m;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++;
    if (rpt_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_hs: valid=%0b ready=%0b want valid=0 ready=1", rpt_valid, in_ready);
    end
    checks++;
    if (rpt_err !== '0 || rpt_sum !== '0 || rpt_max !== '0) begin
      errors++;
      $display("FAIL reset_data: err=%0d sum=%0d max=%0d want 0 0 0", rpt_err, rpt_sum, rpt_max);
    end
  endtask

  task automatic test_identity();
    logic [WIDTH-1:0] g;
    int nvalid;
    nvalid = 0;
    for (int i = 0; i < WIN + 4; i++) begin
      g = rnd_word();
      cyc(i < WIN, g, g, 1'b0, 1'b1);
      if (rpt_valid === 1'b1) nvalid++;
      checks++;
      if (rpt_valid !== m_pending || in_ready !== !m_pending) begin
        errors++;
        $display("FAIL identity_hs: valid=%0b ready=%0b want valid=%0b", rpt_valid, in_ready, m_pending);
      end
      if (rpt_valid === 1'b1) begin
        checks++;
        if (rpt_err !== 32'd0 || rpt_sum !== 32'd0 || rpt_max !== 6'd0) begin
          errors++;
          $display("FAIL identity_data: err=%0d sum=%0d max=%0d want 0 0 0", rpt_err, rpt_sum, rpt_max);
        end
      end
    end
    checks++;
    if (nvalid != 1) begin
      errors++;
      $display("FAIL identity_pulse: valid cycles=%0d want 1", nvalid);
    end
  endtask

  task automatic test_single_bit();
    logic [WIDTH-1:0] g;
    logic [ACC_W-1:0] e1, s1v, e2, s2v;
    logic [HD_W-1:0]  x1, x2;
    e1 = '1; s1v = '1; x1 = '1; e2 = '1; s2v = '1; x2 = '1;
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < WIN + 4; i++) begin
        g = rnd_word();
        if (w == 0) cyc(i < WIN, g ^ 33'h1, g, 1'b0, 1'b1);
        else        cyc(i < WIN, (i == 0) ? (g ^ 33'h1_FFFF_FFFF) : g, g, 1'b0, 1'b1);
        checks++;
        if (rpt_valid !== m_pending || rpt_err !== m_err || rpt_sum !== m_sum || rpt_max !== m_max) begin
          errors++;
          $display("FAIL single_model: valid=%0b err=%0d sum=%0d max=%0d want %0b %0d %0d %0d",
                   rpt_valid, rpt_err, rpt_sum, rpt_max, m_pending, m_err, m_sum, m_max);
        end
        if (rpt_valid === 1'b1 && w == 0) begin e1 = rpt_err; s1v = rpt_sum; x1 = rpt_max; end
        if (rpt_valid === 1'b1 && w == 1) begin e2 = rpt_err; s2v = rpt_sum; x2 = rpt_max; end
      end
    end
    checks++;
    if (e1 !== 32'd8 || s1v !== 32'd8 || x1 !== 6'd1) begin
      errors++;
      $display("FAIL single_win1: err=%0d sum=%0d max=%0d want 8 8 1", e1, s1v, x1);
    end
    checks++;
    if (e2 !== 32'd1 || s2v !== 32'd33 || x2 !== 6'd33) begin
      errors++;
      $display("FAIL single_win2: err=%0d sum=%0d max=%0d want 1 33 33", e2, s2v, x2);
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] g;
    logic [ACC_W-1:0] held;
    int nrpt;
    logic prev;
    held = '0; nrpt = 0; prev = 1'b0;
    for (int i = 0; i < WIN + 22 + 16; i++) begin
      g = rnd_word();
      cyc(1'b1, g ^ rnd_mask(), g, 1'b0, (i >= WIN + 22) ? 1'b1 : 1'b0);
      if (rpt_valid === 1'b1 && prev === 1'b0) begin nrpt++; held = rpt_err; end
      prev = rpt_valid;
      checks++;
      if (rpt_valid !== m_pending || in_ready !== !m_pending) begin
        errors++;
        $display("FAIL bp_hs: valid=%0b ready=%0b want valid=%0b", rpt_valid, in_ready, m_pending);
      end
      checks++;
      if (rpt_err !== m_err || rpt_sum !== m_sum || rpt_max !== m_max || (rpt_valid === 1'b1 && rpt_err !== held)) begin
        errors++;
        $display("FAIL bp_data: err=%0d sum=%0d max=%0d want %0d %0d %0d",
                 rpt_err, rpt_sum, rpt_max, m_err, m_sum, m_max);
      end
    end
    checks++;
    if (nrpt != 2) begin
      errors++;
      $display("FAIL bp_reports: reports=%0d want 2", nrpt);
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_clear();
    logic [WIDTH-1:0] g;
    int nrpt;
    cyc(1'b0, '0, '0, 1'b1, 1'b1);
    nrpt = 0;
    for (int i = 0; i < 5 + 1 + WIN + 4; i++) begin
      g = rnd_word();
      if (i < 5)       cyc(1'b1, g ^ (33'h1 << $urandom_range(32, 0)), g, 1'b0, 1'b1);
      else if (i == 5) cyc(1'b0, '0, '0, 1'b1, 1'b1);
      else             cyc(i < 6 + WIN, g, g, 1'b0, 1'b1);
      if (rpt_valid === 1'b1) begin
        nrpt++;
        checks++;
        if (rpt_err !== 32'd0 || rpt_err !== m_err) begin
          errors++;
          $display("FAIL clear_err: err=%0d want 0", rpt_err);
        end
      end
    end
    checks++;
    if (nrpt != 1) begin
      errors++;
      $display("FAIL clear_reports: reports=%0d want 1", nrpt);
    end
    // Clear lands on the edge that would count the eighth vector.
    nrpt = 0;
    for (int i = 0; i < WIN + 6; i++) begin
      g = rnd_word();
      cyc(i < WIN, g ^ 33'h4, g, (i == WIN + 1) ? 1'b1 : 1'b0, 1'b1);
      if (rpt_valid === 1'b1) nrpt++;
      checks++;
      if (rpt_valid !== m_pending || in_ready !== !m_pending) begin
        errors++;
        $display("FAIL clear_final_hs: valid=%0b ready=%0b want valid=%0b", rpt_valid, in_ready, m_pending);
      end
    end
    checks++;
    if (nrpt != 0) begin
      errors++;
      $display("FAIL clear_final: reports=%0d want 0", nrpt);
    end
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] g;
    for (int i = 0; i < 6; i++) begin
      g = rnd_word();
      cyc(1'b1, g ^ rnd_mask(), g, 1'b0, 1'b1);
    end
    rst_ni = 1'b0;
    #1;
    model_reset();
    checks++;
    if (rpt_valid !== 1'b0 || in_ready !== 1'b1 || rpt_err !== '0 || rpt_sum !== '0 || rpt_max !== '0) begin
      errors++;
      $display("FAIL rst_mid: valid=%0b ready=%0b err=%0d sum=%0d max=%0d want 0 1 0 0 0",
               rpt_valid, in_ready, rpt_err, rpt_sum, rpt_max);
    end
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    for (int i = 0; i < WIN + 4; i++) begin
      g = rnd_word();
      cyc(i < WIN, g ^ rnd_mask(), g, 1'b0, 1'b1);
      checks++;
      if (rpt_valid !== m_pending || rpt_err !== m_err || rpt_sum !== m_sum || rpt_max !== m_max) begin
        errors++;
        $display("FAIL rst_after: valid=%0b err=%0d sum=%0d max=%0d want %0b %0d %0d %0d",
                 rpt_valid, rpt_err, rpt_sum, rpt_max, m_pending, m_err, m_sum, m_max);
      end
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] g;
    for (int i = 0; i < 400; i++) begin
      g = rnd_word();
      cyc($urandom_range(3, 0) != 0, g ^ rnd_mask(), g, $urandom_range(39, 0) == 0,
          $urandom_range(2, 0) != 0);
      checks++;
      if (rpt_valid !== m_pending || in_ready !== !m_pending) begin
        errors++;
        $display("FAIL rand_hs: cyc=%0d valid=%0b ready=%0b want valid=%0b", i, rpt_valid, in_ready, m_pending);
      end
      checks++;
      if (rpt_err !== m_err || rpt_sum !== m_sum || rpt_max !== m_max) begin
        errors++;
        $display("FAIL rand_data: cyc=%0d err=%0d sum=%0d max=%0d want %0d %0d %0d",
                 i, rpt_err, rpt_sum, rpt_max, m_err, m_sum, m_max);
      end
`ifdef LOCK_MON_ABS_ERR_EN
      checks++;
      if (rpt_abs !== m_abs) begin
        errors++;
        $display("FAIL rand_abs: cyc=%0d abs=%0d want %0d", i, rpt_abs, m_abs);
      end
`endif
    end
    for (int i = 0; i < 6; i++) cyc(1'b0, '0, '0, 1'b0, 1'b1);
  endtask

`ifdef LOCK_MON_ABS_ERR_EN
  task automatic test_abs();
    logic [WIDTH-1:0] g, seen;
    seen = '1;
    cyc(1'b0, '0, '0, 1'b1, 1'b1);
    for (int i = 0; i < WIN + 4; i++) begin
      g = WIDTH'($urandom_range(200, 0));
      if (i == 0)      cyc(1'b1, 33'd37, 33'd100, 1'b0, 1'b1);
      else if (i == 1) cyc(1'b1, 33'd300, 33'd5, 1'b0, 1'b1);
      else             cyc(i < WIN, g, g, 1'b0, 1'b1);
      if (rpt_valid === 1'b1) seen = rpt_abs;
    end
    checks++;
    if (seen !== 33'd295) begin
      errors++;
      $display("FAIL abs_max: abs=%0d want 295", seen);
    end
  endtask
`endif

  initial begin
    rst_ni = 1'b0; in_valid = 1'b0; locked = '0; golden = '0; clear = 1'b0; rpt_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    test_reset();
    test_identity();
    test_single_bit();
    test_backpressure();
    test_clear();
    test_reset_mid();
    test_random();
`ifdef LOCK_MON_ABS_ERR_EN
    test_abs();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
